// File: rtl/soft_clock_cmd_master_if.sv
// ============================================================================
//  Module      : soft_clock_cmd_master_if
//  Description : Groups the request/response handshake and the IPIF-style
//                write bus used by soft_clock_cmd_master.
//                master modport : view of the command master (the DUT)
//                slave  modport : view of the requester + clock-gate slave
//  Signals     : Req_Valid/Ready/Enable/Force/Code  request channel
//                Bus2IP_WrCE/Data/BE                write strobe, data, enables
//                Clk2Bus_WrAck/Error/ToutSup        slave answers
//                Rsp_Valid/Status, Clk_Enabled      completion + shadow state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface soft_clock_cmd_master_if #(
    parameter int C_SIPIF_DWIDTH = 32
);
    logic                          Req_Valid;
    logic                          Req_Ready;
    logic                          Req_Enable;
    logic                          Req_Force;
    logic [3:0]                    Req_Code;
    logic                          Bus2IP_WrCE;
    logic [0:C_SIPIF_DWIDTH-1]     Bus2IP_Data;
    logic [0:C_SIPIF_DWIDTH/8-1]   Bus2IP_BE;
    logic                          Clk2Bus_WrAck;
    logic                          Clk2Bus_Error;
    logic                          Clk2Bus_ToutSup;
    logic                          Rsp_Valid;
    logic [1:0]                    Rsp_Status;
    logic                          Clk_Enabled;

    modport master (
        input  Req_Valid, Req_Enable, Req_Force, Req_Code,
        input  Clk2Bus_WrAck, Clk2Bus_Error, Clk2Bus_ToutSup,
        output Req_Ready, Bus2IP_WrCE, Bus2IP_Data, Bus2IP_BE,
        output Rsp_Valid, Rsp_Status, Clk_Enabled
    );

    modport slave (
        output Req_Valid, Req_Enable, Req_Force, Req_Code,
        output Clk2Bus_WrAck, Clk2Bus_Error, Clk2Bus_ToutSup,
        input  Req_Ready, Bus2IP_WrCE, Bus2IP_Data, Bus2IP_BE,
        input  Rsp_Valid, Rsp_Status, Clk_Enabled
    );
endinterface

`default_nettype wire

// File: rtl/soft_clock_cmd_master.sv
// ============================================================================
//  Module      : soft_clock_cmd_master
//  Description : Bus initiator for the soft clock-gate slave. Accepts
//                enable/disable requests, issues a single-beat write held
//                until WrAck/Error or a timeout, retries on timeout, returns
//                one status pulse per request and shadows the clock state.
//  Ports       : Bus2IP_Clk   - sole clock
//                Bus2IP_Reset - synchronous active-high reset
//                bus          - soft_clock_cmd_master_if.master
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soft_clock_cmd_master #(
    parameter int C_SIPIF_DWIDTH = 32,
    parameter int C_TIMEOUT      = 16,
    parameter int C_MAX_RETRY    = 2
) (
    input  wire logic                  Bus2IP_Clk,
    input  wire logic                  Bus2IP_Reset,
    soft_clock_cmd_master_if.master    bus
);

    localparam int DW = C_SIPIF_DWIDTH;
    localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam int RW = (C_MAX_RETRY > 0) ? (($clog2(C_MAX_RETRY + 1) > 0) ? $clog2(C_MAX_RETRY + 1) : 1) : 1;

    localparam logic [3:0]    CODE_EN   = 4'b1010;
    localparam logic [3:0]    CODE_DIS  = 4'b0101;
    localparam logic [TW-1:0] TOUT_LAST = TW'(C_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRY);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q,  state_d;
    logic [3:0]     code_q,   code_d;
    logic           intent_q, intent_d;
    logic [RW-1:0]  retry_q,  retry_d;
    logic [TW-1:0]  tcnt_q,   tcnt_d;
    logic [1:0]     status_q, status_d;
    logic           clken_q,  clken_d;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q  <= S_IDLE;
            code_q   <= 4'b0000;
            intent_q <= 1'b0;
            retry_q  <= '0;
            tcnt_q   <= '0;
            status_q <= ST_OK;
            clken_q  <= 1'b1;   // slave comes out of reset with its clock running
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            intent_q <= intent_d;
            retry_q  <= retry_d;
            tcnt_q   <= tcnt_d;
            status_q <= status_d;
            clken_q  <= clken_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        intent_d = intent_q;
        retry_d  = retry_q;
        tcnt_d   = tcnt_q;
        status_d = status_q;
        clken_d  = clken_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Req_Valid) begin
                    code_d   = bus.Req_Force ? bus.Req_Code
                                             : (bus.Req_Enable ? CODE_EN : CODE_DIS);
                    intent_d = bus.Req_Enable;
                    retry_d  = '0;
                    tcnt_d   = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // WrAck wins over Error, and an answer wins over the timeout
                // check so an ack in the last allowed cycle still succeeds.
                if (bus.Clk2Bus_WrAck) begin
                    status_d = ST_OK;
                    // Only a recognised command changes the slave's gate state.
                    if ((code_q == CODE_EN) || (code_q == CODE_DIS)) begin
                        clken_d = intent_q;
                    end
                    state_d = S_RESP;
                end else if (bus.Clk2Bus_Error) begin
                    status_d = ST_ERR;
                    state_d  = S_RESP;
                end else if (tcnt_q == TOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_GAP;
                    end else begin
                        status_d = ST_TOUT;
                        state_d  = S_RESP;
                    end
                end else if (!bus.Clk2Bus_ToutSup) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                tcnt_d  = '0;
                state_d = S_ISSUE;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic          wrce_w;
    logic [0:DW-1] data_w;

    assign wrce_w = (state_q == S_ISSUE);

    // Code sits in the last four bits of the big-endian bus word.
    always_comb begin
        data_w = '0;
        if (wrce_w) begin
            data_w[DW-4:DW-1] = code_q;
        end
    end

    assign bus.Req_Ready   = (state_q == S_IDLE);
    assign bus.Bus2IP_WrCE = wrce_w;
    assign bus.Bus2IP_Data = data_w;
    assign bus.Bus2IP_BE   = {(DW/8){wrce_w}};
    assign bus.Rsp_Valid   = (state_q == S_RESP);
    assign bus.Rsp_Status  = (state_q == S_RESP) ? status_q : 2'b00;
    assign bus.Clk_Enabled = clken_q;

endmodule

`default_nettype wire

// File: tb/tb_soft_clock_cmd_master.sv
// ============================================================================
//  Module      : tb_soft_clock_cmd_master
//  Description : Directed self-checking bench for soft_clock_cmd_master
//                (DW=32, C_TIMEOUT=16, C_MAX_RETRY=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soft_clock_cmd_master;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    soft_clock_cmd_master_if #(.C_SIPIF_DWIDTH(32)) bus ();

    soft_clock_cmd_master #(
        .C_SIPIF_DWIDTH (32),
        .C_TIMEOUT      (16),
        .C_MAX_RETRY    (2)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Req_Valid       = 1'b0;
        bus.Req_Enable      = 1'b0;
        bus.Req_Force       = 1'b0;
        bus.Req_Code        = 4'b0000;
        bus.Clk2Bus_WrAck   = 1'b0;
        bus.Clk2Bus_Error   = 1'b0;
        bus.Clk2Bus_ToutSup = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.Req_Ready); end
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL reset_wrce got=%b exp=0", bus.Bus2IP_WrCE); end
        checks++; if (bus.Bus2IP_BE !== 4'h0) begin errors++; $display("FAIL reset_be got=%h exp=0", bus.Bus2IP_BE); end
        checks++; if (bus.Bus2IP_Data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.Bus2IP_Data); end
        checks++; if (bus.Rsp_Valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.Rsp_Valid); end
        checks++; if (bus.Rsp_Status !== 2'b00) begin errors++; $display("FAIL reset_status got=%b exp=00", bus.Rsp_Status); end
        checks++; if (bus.Clk_Enabled !== 1'b1) begin errors++; $display("FAIL reset_clk_en got=%b exp=1", bus.Clk_Enabled); end
    endtask

    // Disable request, slave acks in the first WrCE cycle.
    task automatic test_disable_ack();
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b0; bus.Req_Force = 1'b0;
        tick();
        bus.Req_Valid = 1'b0;
        checks++; if (bus.Bus2IP_WrCE !== 1'b1) begin errors++; $display("FAIL dis_wrce got=%b exp=1", bus.Bus2IP_WrCE); end
        checks++; if (bus.Bus2IP_BE !== 4'hF) begin errors++; $display("FAIL dis_be got=%h exp=F", bus.Bus2IP_BE); end
        checks++; if (bus.Bus2IP_Data !== 32'h0000_0005) begin errors++; $display("FAIL dis_data got=%h exp=00000005", bus.Bus2IP_Data); end
        checks++; if (bus.Req_Ready !== 1'b0) begin errors++; $display("FAIL dis_ready_busy got=%b exp=0", bus.Req_Ready); end
        bus.Clk2Bus_WrAck = 1'b1;
        tick();
        bus.Clk2Bus_WrAck = 1'b0;
        checks++; if (bus.Rsp_Valid !== 1'b1) begin errors++; $display("FAIL dis_rsp_valid got=%b exp=1", bus.Rsp_Valid); end
        checks++; if (bus.Rsp_Status !== 2'b00) begin errors++; $display("FAIL dis_status got=%b exp=00", bus.Rsp_Status); end
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL dis_wrce_off got=%b exp=0", bus.Bus2IP_WrCE); end
        checks++; if (bus.Clk_Enabled !== 1'b0) begin errors++; $display("FAIL dis_clk_en got=%b exp=0", bus.Clk_Enabled); end
        tick();
        checks++; if (bus.Rsp_Valid !== 1'b0) begin errors++; $display("FAIL dis_rsp_pulse got=%b exp=0", bus.Rsp_Valid); end
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL dis_ready_idle got=%b exp=1", bus.Req_Ready); end
    endtask

    // Forced illegal code, slave answers Error.
    task automatic test_force_error();
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b1; bus.Req_Force = 1'b1; bus.Req_Code = 4'b0011;
        tick();
        bus.Req_Valid = 1'b0; bus.Req_Force = 1'b0;
        checks++; if (bus.Bus2IP_Data !== 32'h0000_0003) begin errors++; $display("FAIL err_data got=%h exp=00000003", bus.Bus2IP_Data); end
        bus.Clk2Bus_Error = 1'b1;
        tick();
        bus.Clk2Bus_Error = 1'b0;
        checks++; if (bus.Rsp_Valid !== 1'b1) begin errors++; $display("FAIL err_rsp_valid got=%b exp=1", bus.Rsp_Valid); end
        checks++; if (bus.Rsp_Status !== 2'b01) begin errors++; $display("FAIL err_status got=%b exp=01", bus.Rsp_Status); end
        checks++; if (bus.Clk_Enabled !== 1'b0) begin errors++; $display("FAIL err_clk_en got=%b exp=0", bus.Clk_Enabled); end
        tick();
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL err_no_retry got=%b exp=0", bus.Bus2IP_WrCE); end
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL err_ready got=%b exp=1", bus.Req_Ready); end
    endtask

    // Silent slave: bursts at cycles 1-16, 18-33, 35-50 after accept, gaps
    // at 17 and 34, timeout status at cycle 51 (52nd cycle counting accept).
    task automatic test_timeout();
        logic exp_wrce;
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b1;
        for (int k = 1; k <= 53; k++) begin
            tick();
            bus.Req_Valid = 1'b0;
            exp_wrce = ((k >= 1) && (k <= 16)) || ((k >= 18) && (k <= 33)) || ((k >= 35) && (k <= 50));
            checks++; if (bus.Bus2IP_WrCE !== exp_wrce) begin errors++; $display("FAIL tout_wrce cycle=%0d got=%b exp=%b", k, bus.Bus2IP_WrCE, exp_wrce); end
            checks++; if (bus.Rsp_Valid !== (k == 51)) begin errors++; $display("FAIL tout_rsp_valid cycle=%0d got=%b exp=%b", k, bus.Rsp_Valid, (k == 51)); end
            if (k == 51) begin
                checks++; if (bus.Rsp_Status !== 2'b10) begin errors++; $display("FAIL tout_status got=%b exp=10", bus.Rsp_Status); end
            end
        end
        checks++; if (bus.Clk_Enabled !== 1'b0) begin errors++; $display("FAIL tout_clk_en got=%b exp=0", bus.Clk_Enabled); end
    endtask

    // ToutSup for 10 cycles freezes the counter; ack lands in the final
    // allowed cycle (26) which would otherwise be long past the timeout.
    task automatic test_tout_sup();
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            bus.Req_Valid = 1'b0;
            checks++; if (bus.Bus2IP_WrCE !== 1'b1) begin errors++; $display("FAIL sup_wrce cycle=%0d got=%b exp=1", k, bus.Bus2IP_WrCE); end
            bus.Clk2Bus_ToutSup = (k >= 6) && (k <= 15);
            bus.Clk2Bus_WrAck   = (k == 26);
        end
        tick();
        bus.Clk2Bus_WrAck = 1'b0;
        checks++; if (bus.Rsp_Valid !== 1'b1) begin errors++; $display("FAIL sup_rsp_valid got=%b exp=1", bus.Rsp_Valid); end
        checks++; if (bus.Rsp_Status !== 2'b00) begin errors++; $display("FAIL sup_status got=%b exp=00", bus.Rsp_Status); end
        checks++; if (bus.Clk_Enabled !== 1'b1) begin errors++; $display("FAIL sup_clk_en got=%b exp=1", bus.Clk_Enabled); end
        tick();
    endtask

    // Reset during GAP aborts the request silently; a stray ack in IDLE
    // afterwards must not produce a response.
    task automatic test_reset_gap();
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            bus.Req_Valid = 1'b0;
        end
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL rgap_in_gap got=%b exp=0", bus.Bus2IP_WrCE); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL rgap_wrce got=%b exp=0", bus.Bus2IP_WrCE); end
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL rgap_ready got=%b exp=1", bus.Req_Ready); end
        checks++; if (bus.Clk_Enabled !== 1'b1) begin errors++; $display("FAIL rgap_clk_en got=%b exp=1", bus.Clk_Enabled); end
        bus.Clk2Bus_WrAck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.Rsp_Valid !== 1'b0) begin errors++; $display("FAIL rgap_rsp_valid cycle=%0d got=%b exp=0", k, bus.Rsp_Valid); end
            tick();
            bus.Clk2Bus_WrAck = 1'b0;
        end
    endtask

    // Requester holds Req_Valid: disable first (clock goes 1->0... here from 1),
    // then enable, with the second beat answered by WrAck and Error together.
    task automatic test_back_to_back();
        bus.Req_Valid = 1'b1; bus.Req_Enable = 1'b0;
        tick();
        checks++; if (bus.Bus2IP_Data !== 32'h0000_0005) begin errors++; $display("FAIL b2b_data1 got=%h exp=00000005", bus.Bus2IP_Data); end
        bus.Clk2Bus_WrAck = 1'b1;
        tick();
        bus.Clk2Bus_WrAck = 1'b0;
        bus.Req_Enable = 1'b1;
        checks++; if (bus.Rsp_Valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp1 got=%b exp=1", bus.Rsp_Valid); end
        checks++; if (bus.Clk_Enabled !== 1'b0) begin errors++; $display("FAIL b2b_clk_en1 got=%b exp=0", bus.Clk_Enabled); end
        checks++; if (bus.Req_Ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp got=%b exp=0", bus.Req_Ready); end
        tick();
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%b exp=1", bus.Req_Ready); end
        checks++; if (bus.Bus2IP_WrCE !== 1'b0) begin errors++; $display("FAIL b2b_wrce_idle got=%b exp=0", bus.Bus2IP_WrCE); end
        tick();
        bus.Req_Valid = 1'b0;
        checks++; if (bus.Bus2IP_WrCE !== 1'b1) begin errors++; $display("FAIL b2b_wrce2 got=%b exp=1", bus.Bus2IP_WrCE); end
        checks++; if (bus.Bus2IP_Data !== 32'h0000_000A) begin errors++; $display("FAIL b2b_data2 got=%h exp=0000000A", bus.Bus2IP_Data); end
        bus.Clk2Bus_WrAck = 1'b1; bus.Clk2Bus_Error = 1'b1;
        tick();
        bus.Clk2Bus_WrAck = 1'b0; bus.Clk2Bus_Error = 1'b0;
        checks++; if (bus.Rsp_Valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp2 got=%b exp=1", bus.Rsp_Valid); end
        checks++; if (bus.Rsp_Status !== 2'b00) begin errors++; $display("FAIL b2b_status2 got=%b exp=00", bus.Rsp_Status); end
        checks++; if (bus.Clk_Enabled !== 1'b1) begin errors++; $display("FAIL b2b_clk_en2 got=%b exp=1", bus.Clk_Enabled); end
        tick();
        checks++; if (bus.Req_Ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got=%b exp=1", bus.Req_Ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_disable_ack();
        test_force_error();
        test_timeout();
        test_tout_sup();
        test_reset_gap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
